vga_timing_gen: RTL and testbench

VGA 640x480@60 Hz timing generator and pixel output stage for the goose-run display path. Divides the 100 MHz system clock into a 25 MHz pixel tick and runs horizontal/vertical scan counters. Drives the current pixel coordinate (x, y) to the pixel-colour layers (sky, ground, sprites) and samples their 12-bit rgb answer back. Registers that rgb value, blanking-gated, alongside hsync/vsync toward the board's VGA connector.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_tick_gen.sv | 22 ++
 rtl/vga_timing_gen.sv | 85 ++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and colour type for the display path.
// Pixel layers (sky, ground, sprites) import this for rgb12_t and the geometry.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/vga_tick_gen.sv
// System-clock divider producing a one-clk pixel strobe every CLK_DIV clocks.
module vga_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;

    assign p_tick = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      div <= '0;
        else if (p_tick) div <= '0;
        else             div <= div + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan counters plus registered sync/colour output stage; sync and rgb are
// registered on the same pixel tick so they stay aligned one pixel behind x/y.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  rgb12_t      rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        p_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output rgb12_t      rgb_out
);

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic [9:0] h_count, v_count;
    logic       h_end, v_end, h_sync_zone, v_sync_zone;

    vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (p_tick)
    );

    assign h_end       = (h_count == 10'(H_TOT - 1));
    assign v_end       = (v_count == 10'(V_TOT - 1));
    assign h_sync_zone = (h_count >= 10'(HS_START)) && (h_count <= 10'(HS_END));
    assign v_sync_zone = (v_count >= 10'(VS_START)) && (v_count <= 10'(VS_END));

    assign x        = h_count;
    assign y        = v_count;
    assign video_on = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                h_count <= '0;
                v_count <= v_end ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    // Output stage samples the pixel currently on x/y; visible one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= p_tick && h_end && v_end;
            if (p_tick) begin
                hsync   <= ~h_sync_zone;
                vsync   <= ~v_sync_zone;
                rgb_out <= video_on ? rgb_in : 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (24x10) so full frames fit.
module tb_vga_timing_gen;

    localparam int DIV = 4;
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 24
    localparam int VT = VA + VFP + VSW + VBP;   // 10
    localparam int HSS = HA + HFP, HSE = HA + HFP + HSW - 1;  // 18..20
    localparam int VSS = VA + VFP, VSE = VA + VFP + VSW - 1;  // 7..8

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rgb_in;
    logic [9:0]  x, y;
    logic        video_on, p_tick, frame_start, hsync, vsync;
    logic [11:0] rgb_out;

    vga_timing_gen #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .x(x), .y(y),
        .video_on(video_on), .p_tick(p_tick), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, von, rgb, hs, vs, fs;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0, n_bad = 0;
    int   hs_low_cnt = 0, vs_low_cnt = 0, fs_cnt = 0;
    logic [11:0] colors [4] = '{12'h138, 12'hFFF, 12'h0A5, 12'h801};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks strobe cadence, x/y at each tick, registered outputs after it.
    int    k = 0;
    bit    post = 0;
    exp_t  me;
    logic  last_hs = 1'b1, last_vs = 1'b1;
    logic [11:0] last_rgb = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            k = 0; post = 0;
            last_hs = 1'b1; last_vs = 1'b1; last_rgb = '0;
        end else begin
            k++;
            chk("p_tick_cadence", int'(p_tick), int'((k % DIV) == DIV - 1));
            fs_cnt += int'(frame_start);
            if (post) begin
                if (sbq.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    me = sbq.pop_front();
                    chk("rgb_out", int'(rgb_out), me.rgb);
                    chk("hsync", int'(hsync), me.hs);
                    chk("vsync", int'(vsync), me.vs);
                    chk("frame_start", int'(frame_start), me.fs);
                    if (me.fs != 0) begin
                        chk("fs_x0", int'(x), 0);
                        chk("fs_y0", int'(y), 0);
                    end
                end
                hs_low_cnt += int'(!hsync);
                vs_low_cnt += int'(!vsync);
                last_hs = hsync; last_vs = vsync; last_rgb = rgb_out;
                post = 0;
            end else begin
                chk("fs_idle", int'(frame_start), 0);
                chk("hold_hs", int'(hsync), int'(last_hs));
                chk("hold_vs", int'(vsync), int'(last_vs));
                chk("hold_rgb", int'(rgb_out), int'(last_rgb));
            end
            if (p_tick) begin
                if (sbq.size() > 0) begin
                    chk("x", int'(x), sbq[0].x);
                    chk("y", int'(y), sbq[0].y);
                    chk("video_on", int'(video_on), sbq[0].von);
                end else chk("sb_empty_at_tick", 1, 0);
                post = 1;
            end
        end
    end

    // Stimulus: one vector per pixel tick, expected registered response queued.
    task automatic run_ticks(input int n_ticks);
        for (int n = 0; n < n_ticks; n++) begin
            int   h, v;
            bit   got;
            exp_t e;
            h = n % HT;
            v = (n / HT) % VT;
            rgb_in = colors[n % 4];
            e.x   = h;
            e.y   = v;
            e.von = int'(h < HA && v < VA);
            e.rgb = (e.von != 0) ? int'(rgb_in) : 0;
            e.hs  = int'(!(h >= HSS && h <= HSE));
            e.vs  = int'(!(v >= VSS && v <= VSE));
            e.fs  = int'(h == HT - 1 && v == VT - 1);
            sbq.push_back(e);
            got = 0;
            for (int c = 0; c < 2 * DIV && !got; c++) begin
                @(negedge clk);
                if (p_tick) got = 1;
            end
            if (!got) begin
                chk("p_tick_timeout", 0, 1);
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_rgb"}, int'(rgb_out), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_p_tick"}, int'(p_tick), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        rgb_in = 12'h000;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        #1 rst_n = 1'b1;

        // Two full frames then into frame 2 up to pixel (10,3).
        run_ticks(2 * HT * VT + 3 * HT + 10);
        @(posedge clk);
        #2;
        chk("pre_abort_x", int'(x), 10);
        chk("pre_abort_y", int'(y), 3);
        chk("sb_drained", sbq.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Restarted scan: only one frame_start, exactly one frame later.
        run_ticks(HT * VT + 5);
        repeat (2) @(negedge clk);
        chk("sb_final_empty", sbq.size(), 0);
        chk("fs_total", fs_cnt, 3);
        chk("hs_low_ticks", hs_low_cnt, 99);
        chk("vs_low_ticks", vs_low_cnt, 144);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
